acc_feeder: RTL and testbench

//  Producer side of the fp16 accumulator input interface. Buffers raw fp16 words

---
 rtl/acc_feeder.sv | 185 ++++++++++++++++++
 tb/tb_acc_feeder.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_feeder.sv
// Producer side of the fp16 accumulator input: buffers upstream words, classifies them
// into a one-hot type code and marks the first word of every accumulation group.
module acc_feeder #(
    parameter int         DEPTH     = 4,
    parameter logic       MODE      = 1'b0,
    parameter logic [5:0] GROUP_LEN = 6'd2
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        CLR,
    input  logic        EN,
    input  logic        S_VALID,
    output logic        S_READY,
    input  logic [15:0] S_DATA,
    input  logic        S_LAST,
    output logic        DVO,
    output logic        RELEASE,
    output logic [5:0]  DO_TYPE,
    output logic [15:0] DO,
    output logic [15:0] GRP_CNT
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic {
        ST_START = 1'b0,
        ST_MID   = 1'b1
    } grp_state_t;

    logic [16:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [16:0]    head;
    logic [5:0]     head_type;
    grp_state_t     state;
    grp_state_t     state_nx;
    logic [5:0]     wcnt;
    logic [5:0]     wcnt_nx;
    logic           closes;

    // Upstream handshake: a word transfers on a rising CLK edge where S_VALID and S_READY
    // are both high; S_VALID/S_DATA/S_LAST must stay stable until that edge.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign S_READY = !full && !CLR;
    assign push    = S_VALID && S_READY;
    assign pop     = !empty && EN && !CLR;
    assign head    = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {S_LAST, S_DATA};
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (CLR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Exponent all-ones splits into inf / quiet / signalling NaN on the mantissa MSB.
    always_comb begin
        head_type = 6'b100000;
        if (head[14:10] == 5'h1f) begin
            if (head[9:0] == 10'd0) begin
                head_type = 6'b000001;
            end else if (head[9]) begin
                head_type = 6'b000010;
            end else begin
                head_type = 6'b000100;
            end
        end else if (head[14:10] == 5'h00) begin
            if (head[9:0] == 10'd0) begin
                head_type = 6'b001000;
            end else begin
                head_type = 6'b010000;
            end
        end
    end

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        closes   = 1'b0;
        if (pop) begin
            case (state)
                ST_START: begin
                    if (MODE == 1'b0) begin
                        if (head[16]) begin
                            closes = 1'b1;
                        end else begin
                            state_nx = ST_MID;
                        end
                    end else if (GROUP_LEN == 6'd1) begin
                        closes  = 1'b1;
                        wcnt_nx = 6'd0;
                    end else begin
                        state_nx = ST_MID;
                        wcnt_nx  = 6'd1;
                    end
                end
                ST_MID: begin
                    if (MODE == 1'b0) begin
                        if (head[16]) begin
                            closes   = 1'b1;
                            state_nx = ST_START;
                        end
                    end else if (wcnt == GROUP_LEN - 6'd1) begin
                        closes   = 1'b1;
                        state_nx = ST_START;
                        wcnt_nx  = 6'd0;
                    end else begin
                        wcnt_nx = wcnt + 6'd1;
                    end
                end
                default: begin
                    state_nx = ST_START;
                    wcnt_nx  = 6'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= ST_START;
            wcnt  <= 6'd0;
        end else if (CLR) begin
            state <= ST_START;
            wcnt  <= 6'd0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
        end
    end

    // Word fields hold while DVO is low; only DVO and GRP_CNT react to CLR.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            DVO     <= 1'b0;
            RELEASE <= 1'b0;
            DO_TYPE <= 6'd0;
            DO      <= 16'd0;
            GRP_CNT <= 16'd0;
        end else begin
            DVO <= pop;
            if (pop) begin
                DO      <= head[15:0];
                DO_TYPE <= head_type;
                RELEASE <= (state == ST_START);
            end
            if (CLR) begin
                GRP_CNT <= 16'd0;
            end else if (closes) begin
                GRP_CNT <= GRP_CNT + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_acc_feeder.sv
// Bench for acc_feeder: three instances (S_LAST groups, fixed groups of 3, fixed groups of 1)
// share one stimulus stream and are checked every cycle against a queue-based model.
module tb_acc_feeder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr = 1'b0;
    logic        en = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = 16'd0;
    logic        s_last = 1'b0;

    logic        ready [3];
    logic        dvo [3];
    logic        rel [3];
    logic [5:0]  dtype [3];
    logic [15:0] dout [3];
    logic [15:0] grp [3];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit check_on = 1'b0;

    always #5 clk = ~clk;

    acc_feeder #(.DEPTH(DEPTH), .MODE(1'b0), .GROUP_LEN(6'd2)) u0 (
        .CLK(clk), .RSTn(rst_n), .CLR(clr), .EN(en), .S_VALID(s_valid), .S_READY(ready[0]),
        .S_DATA(s_data), .S_LAST(s_last), .DVO(dvo[0]), .RELEASE(rel[0]), .DO_TYPE(dtype[0]),
        .DO(dout[0]), .GRP_CNT(grp[0]));

    acc_feeder #(.DEPTH(DEPTH), .MODE(1'b1), .GROUP_LEN(6'd3)) u1 (
        .CLK(clk), .RSTn(rst_n), .CLR(clr), .EN(en), .S_VALID(s_valid), .S_READY(ready[1]),
        .S_DATA(s_data), .S_LAST(s_last), .DVO(dvo[1]), .RELEASE(rel[1]), .DO_TYPE(dtype[1]),
        .DO(dout[1]), .GRP_CNT(grp[1]));

    acc_feeder #(.DEPTH(DEPTH), .MODE(1'b1), .GROUP_LEN(6'd1)) u2 (
        .CLK(clk), .RSTn(rst_n), .CLR(clr), .EN(en), .S_VALID(s_valid), .S_READY(ready[2]),
        .S_DATA(s_data), .S_LAST(s_last), .DVO(dvo[2]), .RELEASE(rel[2]), .DO_TYPE(dtype[2]),
        .DO(dout[2]), .GRP_CNT(grp[2]));

    // ---------------- reference model ----------------
    int          mode_of [3] = '{0, 1, 1};
    int          gl_of [3]   = '{2, 3, 1};
    logic [16:0] m_q [$];
    logic        m_dvo = 1'b0;
    logic [15:0] m_do = 16'd0;
    logic [5:0]  m_type = 6'd0;
    logic        m_rel [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] m_grp [3] = '{16'd0, 16'd0, 16'd0};
    int          wpos [3] = '{0, 0, 0};

    function automatic logic [5:0] fp_class(input logic [15:0] w);
        logic [14:0] a;
        a = w[14:0];
        if (a == 15'h7C00) return 6'd1;
        if (a > 15'h7C00) return (a >= 15'h7E00) ? 6'd2 : 6'd4;
        if (a == 15'h0000) return 6'd8;
        if (a < 15'h0400) return 6'd16;
        return 6'd32;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int          sz;
        bit          can_push;
        bit          do_pop;
        logic [16:0] w;
        if (!rst_n) begin
            m_q.delete();
            m_dvo = 1'b0;
            m_do = 16'd0;
            m_type = 6'd0;
            for (int i = 0; i < 3; i++) begin
                m_rel[i] = 1'b0;
                m_grp[i] = 16'd0;
                wpos[i] = 0;
            end
        end else begin
            sz = m_q.size();
            can_push = (sz < DEPTH) && !clr;
            do_pop = (sz > 0) && en && !clr;
            if (clr) begin
                m_q.delete();
                m_dvo = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    wpos[i] = 0;
                    m_grp[i] = 16'd0;
                end
            end else if (do_pop) begin
                w = m_q.pop_front();
                m_dvo = 1'b1;
                m_do = w[15:0];
                m_type = fp_class(w[15:0]);
                for (int i = 0; i < 3; i++) begin
                    m_rel[i] = (wpos[i] == 0);
                    wpos[i]++;
                    if ((mode_of[i] == 0 && w[16]) || (mode_of[i] == 1 && wpos[i] == gl_of[i])) begin
                        wpos[i] = 0;
                        m_grp[i] = m_grp[i] + 16'd1;
                    end
                end
            end else begin
                m_dvo = 1'b0;
            end
            if (s_valid && can_push) m_q.push_back({s_last, s_data});
        end
    end

    // ---------------- scoreboard ----------------
    logic [15:0] log_do [$];
    logic [5:0]  log_type [$];
    int          log_cyc [$];
    bit          log_rel0 [$];
    bit          log_rel1 [$];
    bit          log_rel2 [$];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h expected=%0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_on) begin
            cyc++;
            for (int i = 0; i < 3; i++) begin
                check("dvo", i, 32'(dvo[i]), 32'(m_dvo));
                check("do", i, 32'(dout[i]), 32'(m_do));
                check("do_type", i, 32'(dtype[i]), 32'(m_type));
                check("release", i, 32'(rel[i]), 32'(m_rel[i]));
                check("grp_cnt", i, 32'(grp[i]), 32'(m_grp[i]));
                check("s_ready", i, 32'(ready[i]), 32'((m_q.size() < DEPTH) && !clr));
            end
            if (dvo[0]) begin
                log_do.push_back(dout[0]);
                log_type.push_back(dtype[0]);
                log_cyc.push_back(cyc);
                log_rel0.push_back(rel[0]);
            end
            if (dvo[1]) log_rel1.push_back(rel[1]);
            if (dvo[2]) log_rel2.push_back(rel[2]);
        end
    end

    function automatic int mask_of(input bit q[$]);
        int m;
        m = 0;
        foreach (q[j]) if (q[j]) m |= (1 << j);
        return m;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_logs();
        log_do.delete();
        log_type.delete();
        log_cyc.delete();
        log_rel0.delete();
        log_rel1.delete();
        log_rel2.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic l);
        bit acc;
        int n;
        s_valid = 1'b1;
        s_data = d;
        s_last = l;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = ready[0];
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL push_timeout[0] got=not_accepted expected=accepted word=%h", d);
        end
        s_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog[0] got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] t1_words [3] = '{16'h3C00, 16'h4000, 16'h4200};
    logic [15:0] t2_words [7] = '{16'h7C00, 16'h7E00, 16'h7C01, 16'h0000, 16'h8000, 16'h0001, 16'h3C00};
    logic [5:0]  t2_types [7] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b001000, 6'b010000, 6'b100000};
    logic [15:0] t3_words [5] = '{16'h3C00, 16'h4000, 16'h4400, 16'h4800, 16'h4C00};

    initial begin
        #2 rst_n = 1'b0;
        check_on = 1'b1;
        @(posedge clk);
        #1;
        check("rst_dvo", 0, 32'(dvo[0]), 32'd0);
        check("rst_ready", 0, 32'(ready[0]), 32'd1);
        check("rst_grp", 0, 32'(grp[0]), 32'd0);
        check("rst_do", 0, 32'(dout[0]), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // T1: back-to-back issue, S_LAST grouping
        en = 1'b1;
        clear_logs();
        for (int j = 0; j < 3; j++) push(t1_words[j], (j == 1));
        idle(6);
        check("t1_count", 0, 32'(log_do.size()), 32'd3);
        if (log_do.size() == 3) begin
            check("t1_consecutive", 1, 32'(log_cyc[1] - log_cyc[0]), 32'd1);
            check("t1_consecutive", 2, 32'(log_cyc[2] - log_cyc[1]), 32'd1);
            for (int j = 0; j < 3; j++) check("t1_type", j, 32'(log_type[j]), 32'b100000);
        end
        check("t1_release_mask", 0, 32'(mask_of(log_rel0)), 32'h5);
        check("t1_grp", 0, 32'(grp[0]), 32'd1);

        // T2: classification
        clear_logs();
        for (int j = 0; j < 7; j++) push(t2_words[j], 1'b1);
        idle(6);
        check("t2_count", 0, 32'(log_type.size()), 32'd7);
        if (log_type.size() == 7) begin
            for (int j = 0; j < 7; j++) check("t2_type", j, 32'(log_type[j]), 32'(t2_types[j]));
        end

        // T3: fill with EN low, then drain
        en = 1'b0;
        clear_logs();
        for (int j = 0; j < 4; j++) push(t3_words[j], 1'b0);
        s_valid = 1'b1;
        s_data = t3_words[4];
        s_last = 1'b0;
        idle(3);
        check("t3_full_ready", 0, 32'(ready[0]), 32'd0);
        check("t3_no_issue", 0, 32'(log_do.size()), 32'd0);
        en = 1'b1;
        push(t3_words[4], 1'b0);
        idle(8);
        check("t3_count", 0, 32'(log_do.size()), 32'd5);
        if (log_do.size() == 5) begin
            for (int j = 0; j < 5; j++) check("t3_order", j, 32'(log_do[j]), 32'(t3_words[j]));
        end

        // T4: fixed-length groups
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        clear_logs();
        for (int j = 0; j < 7; j++) push(16'h3C00 + 16'(j), 1'b0);
        idle(8);
        check("t4_rel_mask", 1, 32'(mask_of(log_rel1)), 32'h49);
        check("t4_grp", 1, 32'(grp[1]), 32'd2);
        check("t4_rel_mask", 2, 32'(mask_of(log_rel2)), 32'h7F);
        check("t4_grp", 2, 32'(grp[2]), 32'd7);
        check("t4_rel_mask", 0, 32'(mask_of(log_rel0)), 32'h1);

        // T5: CLR with words buffered mid-group
        en = 1'b0;
        push(16'h4400, 1'b0);
        push(16'h4800, 1'b0);
        clear_logs();
        clr = 1'b1;
        idle(1);
        check("t5_dvo", 0, 32'(dvo[0]), 32'd0);
        check("t5_grp", 0, 32'(grp[0]), 32'd0);
        check("t5_grp", 1, 32'(grp[1]), 32'd0);
        clr = 1'b0;
        en = 1'b1;
        idle(3);
        check("t5_flushed", 0, 32'(log_do.size()), 32'd0);
        push(16'h3C00, 1'b0);
        idle(4);
        check("t5_count", 0, 32'(log_do.size()), 32'd1);
        if (log_rel0.size() == 1) check("t5_release", 0, 32'(log_rel0[0]), 32'd1);
        if (log_rel1.size() == 1) check("t5_release", 1, 32'(log_rel1[0]), 32'd1);

        // T6: async reset during issue
        for (int j = 0; j < 3; j++) push(16'h5000 + 16'(j), 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6_dvo", 0, 32'(dvo[0]), 32'd0);
        check("t6_do", 0, 32'(dout[0]), 32'd0);
        check("t6_type", 0, 32'(dtype[0]), 32'd0);
        check("t6_release", 0, 32'(rel[0]), 32'd0);
        check("t6_ready", 0, 32'(ready[0]), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_logs();
        idle(2);
        check("t6_quiet", 0, 32'(log_do.size()), 32'd0);
        push(16'h4000, 1'b0);
        idle(4);
        check("t6_count", 0, 32'(log_do.size()), 32'd1);
        if (log_rel0.size() == 1) check("t6_release", 0, 32'(log_rel0[0]), 32'd1);

        // Random phase, biased toward special exponents
        for (int k = 0; k < 500; k++) begin
            int sel;
            logic [4:0] e;
            logic [9:0] m;
            sel = int'($urandom_range(0, 3));
            e = (sel == 0) ? 5'h1f : (sel == 1) ? 5'h00 : 5'($urandom_range(0, 31));
            m = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom);
            s_valid = 1'($urandom_range(0, 1));
            s_data = {1'($urandom_range(0, 1)), e, m};
            s_last = 1'($urandom_range(0, 2) == 0);
            en = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 39) == 0);
            idle(1);
        end
        s_valid = 1'b0;
        clr = 1'b0;
        en = 1'b1;
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
